// File: rtl/mem_arb.sv
// Two-port (instruction fetch / data) arbiter in front of a single-request memory.
// Round-robin grant, one transaction outstanding, wait-counter timeout reported as nxm.
module mem_arb #(
    parameter int TIMEOUT = 15,
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 36
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              nxm,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              read_ack,
    input  logic              write_ack,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [4:0] TIMEOUT_CNT = 5'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RD, RDATA, WR} state_t;

    state_t     state, state_next;
    logic       gnt_d;
    logic [4:0] wait_cnt;
    logic       i_elig, d_elig, pick_d, grant, timeout;

    // A port showing done this cycle is still holding its old request.
    assign i_elig  = i_req && !i_done;
    assign d_elig  = (d_read || d_write) && !d_done;
    assign pick_d  = d_elig && (!i_elig || !gnt_d);
    assign grant   = (state == IDLE) && (i_elig || d_elig);
    assign timeout = (wait_cnt + 5'd1) == TIMEOUT_CNT;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = (pick_d && d_write && !d_read) ? WR : RD;
                end
            end
            RD: begin
                if (read_ack) begin
                    state_next = RDATA;
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            RDATA:   state_next = IDLE;
            WR: begin
                if (write_ack || timeout) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_read  = (state == RD);
        mem_write = (state == WR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_d          <= 1'b0;
            wait_cnt       <= '0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            i_done         <= 1'b0;
            d_done         <= 1'b0;
            nxm            <= 1'b0;
            i_rdata        <= '0;
            d_rdata        <= '0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            nxm    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        gnt_d    <= pick_d;
                        wait_cnt <= '0;
                        mem_addr <= pick_d ? d_addr : i_addr;
                        if (pick_d) begin
                            mem_write_data <= d_wdata;
                        end
                    end
                end
                RD: begin
                    if (!read_ack) begin
                        wait_cnt <= wait_cnt + 5'd1;
                        if (timeout) begin
                            i_done <= !gnt_d;
                            d_done <= gnt_d;
                            nxm    <= 1'b1;
                            if (gnt_d) begin
                                d_rdata <= '0;
                            end else begin
                                i_rdata <= '0;
                            end
                        end
                    end
                end
                RDATA: begin
                    i_done <= !gnt_d;
                    d_done <= gnt_d;
                    if (gnt_d) begin
                        d_rdata <= mem_read_data;
                    end else begin
                        i_rdata <= mem_read_data;
                    end
                end
                WR: begin
                    if (write_ack) begin
                        i_done <= !gnt_d;
                        d_done <= gnt_d;
                    end else begin
                        wait_cnt <= wait_cnt + 5'd1;
                        if (timeout) begin
                            i_done <= !gnt_d;
                            d_done <= gnt_d;
                            nxm    <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
